hex_scan: RTL and testbench

//  Parametrised multiplexed 7-segment scanner, N_DIGITS hex digits from a packed nibble bus.

---
 rtl/hex_scan_pkg.sv | 17 +
 rtl/hex_scan_if.sv | 25 ++
 rtl/hex_scan_font.sv | 9 +
 rtl/hex_scan.sv | 170 +++++++++++++++++
 tb/tb_hex_scan.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/hex_scan_pkg.sv
// Shared definitions for the hex_scan display scanner: the active-low hex font,
// the all-off segment code and a counter-width helper.
package hex_scan_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // {g,f,e,d,c,b,a}, a segment is lit when its bit is 0
    localparam logic [6:0] FONT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/hex_scan_if.sv
// Pin-side bundle of the hex_scan block: display requests in, scan pins out.
interface hex_scan_if #(
    parameter int N_DIGITS = 8
);
    logic                  en;
    logic [4*N_DIGITS-1:0] disp_data;
    logic [N_DIGITS-1:0]   dp;
    logic [N_DIGITS-1:0]   blank_mask;
    logic                  lz_blank;
    logic [3:0]            brightness;
    logic [N_DIGITS-1:0]   sel;
    logic [6:0]            seg;
    logic                  dp_out;
    logic                  frame_tick;

    modport master (
        output en, disp_data, dp, blank_mask, lz_blank, brightness,
        input  sel, seg, dp_out, frame_tick
    );

    modport slave (
        input  en, disp_data, dp, blank_mask, lz_blank, brightness,
        output sel, seg, dp_out, frame_tick
    );
endinterface

// File: rtl/hex_scan_font.sv
// Nibble to 7-segment lookup; the code is always active-low, the parent applies polarity.
module hex_scan_font
    import hex_scan_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] code
);
    assign code = FONT[nibble];
endmodule

// File: rtl/hex_scan.sv
// Multiplexed N-digit hex 7-segment scanner with frame-synchronous shadow latch,
// anti-ghost guard, blanking and decimal points. Define HEX_SCAN_DIM_EN to build PWM dimming.
module hex_scan
    import hex_scan_pkg::*;
#(
    parameter int CLK_HZ         = 50_000_000,
    parameter int SCAN_HZ        = 1000,
    parameter int N_DIGITS       = 8,
    parameter int GUARD_CYCLES   = 2,
    parameter int SEL_ACTIVE_LOW = 0,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input logic       clk,
    input logic       reset,
    hex_scan_if.slave bus
);
    localparam int DIV = CLK_HZ / SCAN_HZ;
    localparam int CW  = int'(cnt_width(DIV));
    localparam int IW  = int'(cnt_width(N_DIGITS));

    localparam logic [CW-1:0]       CNT_LAST = CW'(DIV - 1);
    localparam logic [IW-1:0]       IDX_LAST = IW'(N_DIGITS - 1);
    localparam logic [N_DIGITS-1:0] SEL_ONE  = N_DIGITS'(1);
    localparam logic [N_DIGITS-1:0] SEL_IDLE = (SEL_ACTIVE_LOW != 0) ? {N_DIGITS{1'b1}} : '0;
    localparam logic [6:0]          SEG_DARK = (SEG_ACTIVE_LOW != 0) ? SEG_OFF : ~SEG_OFF;
    localparam logic                DP_DARK  = (SEG_ACTIVE_LOW != 0);

    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [4*N_DIGITS-1:0] disp_s_q, disp_s_d;
    logic [N_DIGITS-1:0]   dp_s_q, dp_s_d;
    logic [N_DIGITS-1:0]   blank_s_q, blank_s_d;
    logic                  lz_s_q, lz_s_d;
    logic [N_DIGITS-1:0]   sel_q, sel_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_out_q, dp_out_d;
    logic                  frame_tick_q, frame_tick_d;

    logic                  frame_load;
    logic [N_DIGITS-1:0]   dark;
    logic                  zero_run;
    logic [31:0]           on_cnt;
    logic [3:0]            nibble;
    logic [6:0]            font_code;
    logic                  digit_on;
    logic                  in_window;

    // Prescaler and digit index; disabling parks the scan at digit 0, cnt 0.
    always_comb begin
        cnt_d = cnt_q;
        idx_d = idx_q;
        if (!bus.en) begin
            cnt_d = '0;
            idx_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    assign frame_load = (cnt_d == '0) && (idx_d == '0);

    always_comb begin
        disp_s_d  = frame_load ? bus.disp_data  : disp_s_q;
        dp_s_d    = frame_load ? bus.dp         : dp_s_q;
        blank_s_d = frame_load ? bus.blank_mask : blank_s_q;
        lz_s_d    = frame_load ? bus.lz_blank   : lz_s_q;
    end

    // A digit is lz-dark when it and every more-significant nibble are zero.
    always_comb begin
        dark     = blank_s_q;
        zero_run = 1'b1;
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            zero_run = zero_run && (disp_s_q[4*i +: 4] == 4'h0);
            if (lz_s_q && zero_run) begin
                dark[i] = 1'b1;
            end
        end
    end

`ifdef HEX_SCAN_DIM_EN
    logic [3:0]  bright_s_q, bright_s_d;
    logic [31:0] on_raw;

    assign bright_s_d = frame_load ? bus.brightness : bright_s_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bright_s_q <= '0;
        end else begin
            bright_s_q <= bright_s_d;
        end
    end

    always_comb begin
        on_raw = ((32'(bright_s_q) + 32'd1) * 32'(DIV)) >> 4;
        on_cnt = on_raw;
        if (on_raw > 32'(DIV)) begin
            on_cnt = 32'(DIV);
        end
        if (on_raw < 32'(GUARD_CYCLES + 1)) begin
            on_cnt = 32'(GUARD_CYCLES + 1);
        end
    end
`else
    logic unused_brightness;

    assign unused_brightness = ^bus.brightness;
    assign on_cnt            = 32'(DIV);
`endif

    assign nibble = disp_s_q[{idx_q, 2'b00} +: 4];

    hex_scan_font u_font (
        .nibble (nibble),
        .code   (font_code)
    );

    // Output stage: seg shows through the guard, sel and dp only inside the on window.
    always_comb begin
        sel_d        = SEL_IDLE;
        seg_d        = SEG_DARK;
        dp_out_d     = DP_DARK;
        digit_on     = bus.en && !dark[idx_q];
        in_window    = (32'(cnt_q) >= 32'(GUARD_CYCLES)) && (32'(cnt_q) < on_cnt);
        frame_tick_d = bus.en && (cnt_q == '0) && (idx_q == '0);
        if (digit_on) begin
            seg_d = (SEG_ACTIVE_LOW != 0) ? font_code : ~font_code;
            if (in_window) begin
                sel_d    = SEL_IDLE ^ (SEL_ONE << idx_q);
                dp_out_d = dp_s_q[idx_q] ? ~DP_DARK : DP_DARK;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            disp_s_q     <= '0;
            dp_s_q       <= '0;
            blank_s_q    <= '0;
            lz_s_q       <= 1'b0;
            sel_q        <= SEL_IDLE;
            seg_q        <= SEG_DARK;
            dp_out_q     <= DP_DARK;
            frame_tick_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            disp_s_q     <= disp_s_d;
            dp_s_q       <= dp_s_d;
            blank_s_q    <= blank_s_d;
            lz_s_q       <= lz_s_d;
            sel_q        <= sel_d;
            seg_q        <= seg_d;
            dp_out_q     <= dp_out_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign bus.sel        = sel_q;
    assign bus.seg        = seg_q;
    assign bus.dp_out     = dp_out_q;
    assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_hex_scan.sv
// Directed bench for hex_scan: 4 digits, DIV=10, guard 2; sample j of a frame is
// the output for slot j/10, cnt j%10, with j=0 the frame_tick sample.
module tb_hex_scan;
    localparam int N = 4;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    hex_scan_if #(.N_DIGITS(N)) dif ();

    hex_scan #(
        .CLK_HZ         (1000),
        .SCAN_HZ        (100),
        .N_DIGITS       (N),
        .GUARD_CYCLES   (2),
        .SEL_ACTIVE_LOW (0),
        .SEG_ACTIVE_LOW (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dif)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_frame();
        bit seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            step();
            if (dif.frame_tick === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL wait_frame: frame_tick stayed 0 for 100 cycles, required 1");
        end
    endtask

    // Inputs already set: park with en=0 so the shadow reloads, then start a frame.
    task automatic restart();
        dif.en = 1'b0;
        step();
        step();
        dif.en = 1'b1;
        wait_frame();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        dif.en = 1'b0;
        dif.disp_data = '0;
        dif.dp = '0;
        dif.blank_mask = '0;
        dif.lz_blank = 1'b0;
        dif.brightness = 4'hF;
        #1 reset = 1'b1;
        #2;
        checks++; if (dif.sel !== 4'b0000) begin errors++; $display("FAIL reset_sel: got %b, required 0000", dif.sel); end
        checks++; if (dif.seg !== 7'h7F) begin errors++; $display("FAIL reset_seg: got %h, required 7f", dif.seg); end
        checks++; if (dif.dp_out !== 1'b1) begin errors++; $display("FAIL reset_dp: got %b, required 1", dif.dp_out); end
        checks++; if (dif.frame_tick !== 1'b0) begin errors++; $display("FAIL reset_ft: got %b, required 0", dif.frame_tick); end
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_scan();
        logic [6:0] tab [4];
        logic [3:0] exp_sel;
        logic       exp_ft;
        int         s, c;
        tab = '{7'h19, 7'h30, 7'h24, 7'h79};
        dif.disp_data = 16'h1234;
        restart();
        for (int j = 0; j <= 40; j++) begin
            if (j > 0) step();
            s = (j / 10) % 4;
            c = j % 10;
            exp_sel = (c >= 2) ? 4'(1 << s) : 4'b0000;
            exp_ft = ((j % 40) == 0);
            checks++; if (dif.sel !== exp_sel) begin errors++; $display("FAIL scan_sel j=%0d: got %b, required %b", j, dif.sel, exp_sel); end
            checks++; if (dif.frame_tick !== exp_ft) begin errors++; $display("FAIL scan_ft j=%0d: got %b, required %b", j, dif.frame_tick, exp_ft); end
            checks++; if (dif.dp_out !== 1'b1) begin errors++; $display("FAIL scan_dp j=%0d: got %b, required 1", j, dif.dp_out); end
            if (c >= 2) begin
                checks++; if (dif.seg !== tab[s]) begin errors++; $display("FAIL scan_seg j=%0d: got %h, required %h", j, dif.seg, tab[s]); end
            end
        end
    endtask

    task automatic test_tear();
        logic [6:0] tab [4];
        logic [6:0] exp_seg;
        logic [3:0] exp_sel;
        int         s, c;
        tab = '{7'h19, 7'h30, 7'h24, 7'h79};
        dif.disp_data = 16'h1234;
        restart();
        for (int j = 0; j < 80; j++) begin
            if (j > 0) step();
            s = (j / 10) % 4;
            c = j % 10;
            exp_sel = (c >= 2) ? 4'(1 << s) : 4'b0000;
            exp_seg = (j < 40) ? tab[s] : 7'h0E;
            checks++; if (dif.sel !== exp_sel) begin errors++; $display("FAIL tear_sel j=%0d: got %b, required %b", j, dif.sel, exp_sel); end
            if (c >= 2) begin
                checks++; if (dif.seg !== exp_seg) begin errors++; $display("FAIL tear_seg j=%0d: got %h, required %h", j, dif.seg, exp_seg); end
            end
            if (j == 22) dif.disp_data = 16'hFFFF;
        end
    endtask

    task automatic test_lz();
        logic [6:0] tab [4];
        logic [3:0] dark;
        logic [3:0] exp_sel;
        logic [6:0] exp_seg;
        int         s, c;
        dif.lz_blank = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 0) begin
                dif.disp_data = 16'h0050;
                tab = '{7'h40, 7'h12, 7'h7F, 7'h7F};
                dark = 4'b1100;
            end else begin
                dif.disp_data = 16'h0000;
                tab = '{7'h40, 7'h7F, 7'h7F, 7'h7F};
                dark = 4'b1110;
            end
            restart();
            for (int j = 0; j < 40; j++) begin
                if (j > 0) step();
                s = j / 10;
                c = j % 10;
                exp_sel = (c >= 2 && !dark[s]) ? 4'(1 << s) : 4'b0000;
                exp_seg = tab[s];
                checks++; if (dif.sel !== exp_sel) begin errors++; $display("FAIL lz_sel p=%0d j=%0d: got %b, required %b", pass, j, dif.sel, exp_sel); end
                if (c >= 2 || dark[s]) begin
                    checks++; if (dif.seg !== exp_seg) begin errors++; $display("FAIL lz_seg p=%0d j=%0d: got %h, required %h", pass, j, dif.seg, exp_seg); end
                end
            end
        end
        dif.lz_blank = 1'b0;
    endtask

    task automatic test_dp_blank();
        logic [6:0] tab [4];
        logic [3:0] exp_sel;
        logic       exp_dp;
        int         s, c;
        tab = '{7'h7F, 7'h30, 7'h24, 7'h79};
        dif.disp_data = 16'h1234;
        dif.dp = 4'b0010;
        dif.blank_mask = 4'b0001;
        restart();
        for (int j = 0; j < 40; j++) begin
            if (j > 0) step();
            s = j / 10;
            c = j % 10;
            exp_sel = (c >= 2 && s != 0) ? 4'(1 << s) : 4'b0000;
            exp_dp = !(c >= 2 && s == 1);
            checks++; if (dif.sel !== exp_sel) begin errors++; $display("FAIL dpb_sel j=%0d: got %b, required %b", j, dif.sel, exp_sel); end
            checks++; if (dif.dp_out !== exp_dp) begin errors++; $display("FAIL dpb_dp j=%0d: got %b, required %b", j, dif.dp_out, exp_dp); end
            if (c >= 2 || s == 0) begin
                checks++; if (dif.seg !== tab[s]) begin errors++; $display("FAIL dpb_seg j=%0d: got %h, required %h", j, dif.seg, tab[s]); end
            end
        end
        dif.dp = '0;
        dif.blank_mask = '0;
    endtask

    task automatic test_brightness();
        logic [3:0] exp_sel;
        int         s, c, top;
        dif.disp_data = 16'h1234;
        for (int pass = 0; pass < 2; pass++) begin
            dif.brightness = (pass == 0) ? 4'd7 : 4'd15;
`ifdef HEX_SCAN_DIM_EN
            top = (pass == 0) ? 5 : 10;
`else
            top = 10;
`endif
            restart();
            for (int j = 0; j < 40; j++) begin
                if (j > 0) step();
                s = j / 10;
                c = j % 10;
                exp_sel = (c >= 2 && c < top) ? 4'(1 << s) : 4'b0000;
                checks++; if (dif.sel !== exp_sel) begin errors++; $display("FAIL bright_sel b=%0d j=%0d: got %b, required %b", dif.brightness, j, dif.sel, exp_sel); end
            end
        end
        dif.brightness = 4'hF;
    endtask

    task automatic test_disable();
        logic [3:0] exp_sel;
        dif.disp_data = 16'h1234;
        restart();
        for (int j = 1; j <= 13; j++) step();
        checks++; if (dif.sel !== 4'b0010) begin errors++; $display("FAIL dis_pre_sel: got %b, required 0010", dif.sel); end
        dif.en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (dif.sel !== 4'b0000) begin errors++; $display("FAIL dis_sel k=%0d: got %b, required 0000", k, dif.sel); end
            checks++; if (dif.seg !== 7'h7F) begin errors++; $display("FAIL dis_seg k=%0d: got %h, required 7f", k, dif.seg); end
            checks++; if (dif.frame_tick !== 1'b0) begin errors++; $display("FAIL dis_ft k=%0d: got %b, required 0", k, dif.frame_tick); end
        end
        dif.en = 1'b1;
        step();
        checks++; if (dif.frame_tick !== 1'b1) begin errors++; $display("FAIL dis_re_ft: got %b, required 1", dif.frame_tick); end
        for (int j = 1; j < 10; j++) begin
            step();
            exp_sel = (j >= 2) ? 4'b0001 : 4'b0000;
            checks++; if (dif.sel !== exp_sel) begin errors++; $display("FAIL dis_re_sel j=%0d: got %b, required %b", j, dif.sel, exp_sel); end
            checks++; if (dif.frame_tick !== 1'b0) begin errors++; $display("FAIL dis_re_ft j=%0d: got %b, required 0", j, dif.frame_tick); end
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] exp_sel;
        dif.disp_data = 16'h1234;
        restart();
        for (int j = 1; j <= 15; j++) step();
        checks++; if (dif.sel !== 4'b0010) begin errors++; $display("FAIL rmid_pre_sel: got %b, required 0010", dif.sel); end
        #3 reset = 1'b1;
        #1;
        checks++; if (dif.sel !== 4'b0000) begin errors++; $display("FAIL rmid_sel: got %b, required 0000", dif.sel); end
        checks++; if (dif.seg !== 7'h7F) begin errors++; $display("FAIL rmid_seg: got %h, required 7f", dif.seg); end
        checks++; if (dif.dp_out !== 1'b1) begin errors++; $display("FAIL rmid_dp: got %b, required 1", dif.dp_out); end
        checks++; if (dif.frame_tick !== 1'b0) begin errors++; $display("FAIL rmid_ft: got %b, required 0", dif.frame_tick); end
        #2 reset = 1'b0;
        step();
        checks++; if (dif.frame_tick !== 1'b1) begin errors++; $display("FAIL rmid_restart_ft: got %b, required 1", dif.frame_tick); end
        for (int j = 1; j < 10; j++) begin
            step();
            exp_sel = (j >= 2) ? 4'b0001 : 4'b0000;
            checks++; if (dif.sel !== exp_sel) begin errors++; $display("FAIL rmid_restart_sel j=%0d: got %b, required %b", j, dif.sel, exp_sel); end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_tear();
        test_lz();
        test_dp_blank();
        test_brightness();
        test_disable();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
